mem_bus_arbiter: RTL and testbench

- Two-master arbiter and sequencer for the shared data-memory/peripheral bus; it drives the same read/write strobe, address and write-data signals that the Bus module consumes.
- Master 0 is the CPU data port; master 1 is a DMA/peripheral engine.
- Grants the bus round-robin and registers each transaction.
- Holds the bus strobes for a fixed access time, then returns a one-cycle ack with read data.
- Supports a lock so one master can perform atomic multi-transaction sequences.

---
 rtl/mem_bus_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master bus arbiter and sequencer. Grants the shared memory/peripheral bus
// round-robin (or fixed priority), latches the winning transaction, holds the
// bus strobes for ACCESS_CYCLES cycles, and then returns a one-cycle ack with
// read data. A master can lock the bus across several transactions.
module mem_bus_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 1,
  parameter bit          FIXED_PRIO    = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic        m0_lock,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic        m1_lock,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic [1:0]  grant,
  output logic        bus_read,
  output logic        bus_write,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  localparam logic [3:0] AccessLoad = 4'(ACCESS_CYCLES);

  state_e      state_q, state_d;
  logic        winner_q, winner_d;           // 0 = master 0, 1 = master 1
  logic        last_winner_q, last_winner_d;
  logic        lock_q, lock_d;               // bus locked to last_winner_q
  logic        lock_lat_q, lock_lat_d;       // lock request of the current transaction
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;
  logic        m0_win, m1_win;

  // Arbitration among pending requests; only meaningful while idle.
  always_comb begin
    m0_win = 1'b0;
    m1_win = 1'b0;
    if (lock_q) begin
      // The locked master is always the one that won last.
      m0_win = m0_req && !last_winner_q;
      m1_win = m1_req && last_winner_q;
    end else if (m0_req && m1_req) begin
      m0_win = FIXED_PRIO || last_winner_q;
      m1_win = !m0_win;
    end else begin
      m0_win = m0_req;
      m1_win = m1_req;
    end
  end

  // Next-state logic for the sequencer and its holding registers.
  always_comb begin
    state_d       = state_q;
    winner_d      = winner_q;
    last_winner_d = last_winner_q;
    lock_d        = lock_q;
    lock_lat_d    = lock_lat_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    cnt_d         = cnt_q;
    m0_rdata_d    = m0_rdata_q;
    m1_rdata_d    = m1_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (m0_win) begin
          winner_d   = 1'b0;
          we_d       = m0_we;
          addr_d     = m0_addr;
          wdata_d    = m0_wdata;
          lock_lat_d = m0_lock;
          cnt_d      = AccessLoad;
          state_d    = StAccess;
        end else if (m1_win) begin
          winner_d   = 1'b1;
          we_d       = m1_we;
          addr_d     = m1_addr;
          wdata_d    = m1_wdata;
          lock_lat_d = m1_lock;
          cnt_d      = AccessLoad;
          state_d    = StAccess;
        end
      end
      StAccess: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          if (!we_q) begin
            if (winner_q) m1_rdata_d = bus_rdata;
            else          m0_rdata_d = bus_rdata;
          end
          state_d = StResp;
        end
      end
      StResp: begin
        last_winner_d = winner_q;
        lock_d        = lock_lat_q;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Bus strobes, grant and acks decoded from the current state.
  always_comb begin
    grant     = 2'b00;
    bus_read  = 1'b0;
    bus_write = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    unique case (state_q)
      StAccess: begin
        grant     = winner_q ? 2'b10 : 2'b01;
        bus_read  = !we_q;
        bus_write = we_q;
        bus_addr  = addr_q;
        bus_wdata = wdata_q;
      end
      StResp: begin
        grant  = winner_q ? 2'b10 : 2'b01;
        m0_ack = !winner_q;
        m1_ack = winner_q;
      end
      default: ;
    endcase
  end

  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;

  // State registers; reset discards any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      winner_q      <= 1'b0;
      last_winner_q <= 1'b1;
      lock_q        <= 1'b0;
      lock_lat_q    <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      cnt_q         <= '0;
      m0_rdata_q    <= '0;
      m1_rdata_q    <= '0;
    end else begin
      state_q       <= state_d;
      winner_q      <= winner_d;
      last_winner_q <= last_winner_d;
      lock_q        <= lock_d;
      lock_lat_q    <= lock_lat_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      cnt_q         <= cnt_d;
      m0_rdata_q    <= m0_rdata_d;
      m1_rdata_q    <= m1_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: scenarios push expected transactions in
// arbitration order; a negedge monitor checks every bus access and every ack.
module tb_mem_bus_arbiter;

  localparam int unsigned AC = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0, m0_lock = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic        m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic        m0_ack, m1_ack, bus_read, bus_write;
  logic [31:0] m0_rdata, m1_rdata, bus_addr, bus_wdata, bus_rdata;
  logic [1:0]  grant;

  int vectors = 0;
  int miscompares = 0;
  int strobe_cnt = 0;
  bit rst_seen;

  typedef struct {
    bit          m;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  mem_bus_arbiter #(.ACCESS_CYCLES(AC), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .grant(grant), .bus_read(bus_read), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  // Bus slave: 0x10 holds 0xDEADBEEF, every other address reads {a[15:0], ~a[15:0]}.
  assign bus_rdata = (bus_addr == 32'h10) ? 32'hDEADBEEF : {bus_addr[15:0], ~bus_addr[15:0]};

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endfunction

  function automatic void push(bit m, bit we, logic [31:0] a, logic [31:0] d, logic [31:0] rd);
    exp_t e;
    e.m = m; e.we = we; e.addr = a; e.wdata = d; e.rdata = rd;
    exp_q.push_back(e);
  endfunction

  // One transaction from master m: raise req, wait for ack, drop req after the next edge.
  task automatic xfer(input bit m, input bit we, input bit lk, input logic [31:0] a,
                      input logic [31:0] d);
    bit seen = 1'b0;
    if (!m) begin m0_req = 1; m0_we = we; m0_lock = lk; m0_addr = a; m0_wdata = d; end
    else    begin m1_req = 1; m1_we = we; m1_lock = lk; m1_addr = a; m1_wdata = d; end
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      seen = m ? m1_ack : m0_ack;
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL ack_timeout m%0d addr %h: got no ack, required ack", m, a);
    end
    @(posedge clk);
    #1;
    if (!m) m0_req = 0; else m1_req = 0;
  endtask

  // Monitor: checks each strobe cycle and each ack against the scoreboard head.
  initial begin
    exp_t e;
    logic [1:0]  req_grant;
    logic [31:0] act_rd;
    bit          act_m;
    forever begin
      @(negedge clk);
      if (!reset) begin
        strobe_cnt = 0;
      end else begin
        if (bus_read && bus_write) begin
          miscompares++;
          $display("FAIL strobe_overlap: got read=1 write=1, required at most one");
        end
        if (m0_ack && m1_ack) begin
          miscompares++;
          $display("FAIL ack_overlap: got m0_ack=1 m1_ack=1, required at most one");
        end
        if (bus_read || bus_write) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_access: got addr %h, required no access", bus_addr);
          end else begin
            e = exp_q[0];
            req_grant = e.m ? 2'b10 : 2'b01;
            strobe_cnt++;
            if (grant !== req_grant || bus_addr !== e.addr || bus_write !== e.we ||
                bus_read !== !e.we || (e.we && bus_wdata !== e.wdata)) begin
              miscompares++;
              $display("FAIL bus_access: got grant=%b addr=%h we=%b wdata=%h, required grant=%b addr=%h we=%b wdata=%h",
                       grant, bus_addr, bus_write, bus_wdata, req_grant, e.addr, e.we, e.wdata);
            end
          end
        end
        if (m0_ack || m1_ack) begin
          vectors++;
          act_m  = m1_ack;
          act_rd = act_m ? m1_rdata : m0_rdata;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_ack: got ack from m%0d, required none", act_m);
          end else begin
            e = exp_q.pop_front();
            req_grant = e.m ? 2'b10 : 2'b01;
            if (act_m !== e.m || act_rd !== e.rdata || grant !== req_grant ||
                strobe_cnt != int'(AC)) begin
              miscompares++;
              $display("FAIL ack: got m%0d rdata=%h grant=%b strobes=%0d, required m%0d rdata=%h grant=%b strobes=%0d",
                       act_m, act_rd, grant, strobe_cnt, e.m, e.rdata, req_grant, AC);
            end
          end
          strobe_cnt = 0;
        end
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    @(negedge clk);
    chk("reset_grant", {30'd0, grant}, 32'd0);
    chk("reset_ctrl", {28'd0, bus_read, bus_write, m0_ack, m1_ack}, 32'd0);
    chk("reset_m0_rdata", m0_rdata, 32'd0);
    chk("reset_m1_rdata", m1_rdata, 32'd0);

    // Simultaneous back-to-back requests alternate 0,1,0,1; m0 wins the first tie.
    push(0, 0, 32'h10, 32'h0, 32'hDEADBEEF);
    push(1, 0, 32'h1234, 32'h0, 32'h1234EDCB);
    push(0, 0, 32'h20, 32'h0, 32'h0020FFDF);
    push(1, 1, 32'h40000000, 32'h12345678, 32'h1234EDCB);
    @(posedge clk); #1;
    fork
      begin xfer(0, 0, 0, 32'h10, 32'h0); xfer(0, 0, 0, 32'h20, 32'h0); end
      begin xfer(1, 0, 0, 32'h1234, 32'h0); xfer(1, 1, 0, 32'h40000000, 32'h12345678); end
    join

    // Lock: m0 holds the bus for three transactions while m1 waits.
    push(0, 0, 32'h20, 32'h0, 32'h0020FFDF);
    push(0, 1, 32'h1234, 32'hCAFEF00D, 32'h0020FFDF);
    push(0, 0, 32'h40000004, 32'h0, 32'h0004FFFB);
    push(1, 0, 32'h10, 32'h0, 32'hDEADBEEF);
    fork
      begin
        xfer(0, 0, 1, 32'h20, 32'h0);
        xfer(0, 1, 1, 32'h1234, 32'hCAFEF00D);
        xfer(0, 0, 0, 32'h40000004, 32'h0);
      end
      xfer(1, 0, 0, 32'h10, 32'h0);
    join

    // Reset mid-access: strobes drop at once, no ack, then m1's held request is redone.
    push(1, 0, 32'h20, 32'h0, 32'h0020FFDF);
    fork
      xfer(1, 0, 0, 32'h20, 32'h0);
      begin
        rst_seen = 1'b0;
        for (int i = 0; i < 20 && !rst_seen; i++) begin
          @(negedge clk);
          rst_seen = bus_read;
        end
        chk("reset_window_reached", {31'd0, rst_seen}, 32'd1);
        #2 reset = 1'b0;
        #1 chk("async_reset_outputs", {27'd0, grant, bus_read, bus_write, m0_ack | m1_ack},
               32'd0);
        exp_q.delete();
        push(1, 0, 32'h20, 32'h0, 32'h0020FFDF);
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
      end
    join

    // Write after reset leaves m0_rdata at its reset value.
    push(0, 1, 32'h44, 32'h55, 32'h0);
    xfer(0, 1, 0, 32'h44, 32'h55);

    repeat (4) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
